// File: rtl/cordic_osc_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : cordic_osc_scheduler
//  Description : Round-robin time-sharing of one pipelined sin/cos CORDIC among
//                N_REQ oscillator partials, with a latency-matched tag pipe.
//                Optional statistics counters: define CORDIC_SCHED_STATS_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module cordic_osc_scheduler #(
    parameter int N_REQ   = 4,
    parameter int LATENCY = 20,
    parameter int ANGLE_W = 14,
    parameter int OUT_W   = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic [N_REQ-1:0]           req_valid,
    input  logic [N_REQ*ANGLE_W-1:0]   req_angle,
    output logic [N_REQ-1:0]           req_ready,
    output logic [ANGLE_W-1:0]         cordic_angle,
    output logic                       cordic_angle_valid,
    input  logic [OUT_W-1:0]           cordic_sin,
    input  logic [OUT_W-1:0]           cordic_cos,
    input  logic                       cordic_out_valid,
    output logic                       res_valid,
    output logic [$clog2(N_REQ)-1:0]   res_idx,
    output logic [OUT_W-1:0]           res_sin,
    output logic [OUT_W-1:0]           res_cos,
    output logic                       err
`ifdef CORDIC_SCHED_STATS_EN
   ,output logic [31:0]                stat_issued,
    output logic [31:0]                stat_stall
`endif
);

    localparam int c_IDX_W   = $clog2(N_REQ);
    localparam int c_FLUSH_W = $clog2(LATENCY + 2);
    localparam logic [c_FLUSH_W-1:0] c_FLUSH_INIT = c_FLUSH_W'(LATENCY + 1);

    logic [c_IDX_W-1:0]   r_ptr;
    logic [c_IDX_W-1:0]   r_issue_idx;
    logic [c_FLUSH_W-1:0] r_flush_cnt;
    logic [LATENCY-1:0]   r_tag_v;
    logic [c_IDX_W-1:0]   r_tag_idx [LATENCY];

    logic                 w_flush;
    logic                 w_fire;
    logic [c_IDX_W-1:0]   w_gnt_idx;
    logic [c_IDX_W-1:0]   w_cand;
    logic [N_REQ-1:0]     w_grant;
    int                   w_j;
    logic                 w_tag_v;

    assign w_flush   = (r_flush_cnt != '0);
    assign w_tag_v   = r_tag_v[LATENCY-1];
    assign req_ready = w_grant;

    // First valid requester at or after the round-robin pointer wins.
    always_comb begin
        w_grant   = '0;
        w_gnt_idx = '0;
        w_cand    = '0;
        w_fire    = 1'b0;
        w_j       = 0;
        if (en && !w_flush) begin
            for (int k = 0; k < N_REQ; k++) begin
                w_j = int'(r_ptr) + k;
                if (w_j >= N_REQ) begin
                    w_j = w_j - N_REQ;
                end
                w_cand = c_IDX_W'(w_j);
                if (!w_fire && req_valid[w_cand]) begin
                    w_fire    = 1'b1;
                    w_gnt_idx = w_cand;
                end
            end
        end
        if (w_fire) begin
            w_grant = N_REQ'(1) << w_gnt_idx;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr              <= '0;
            r_issue_idx        <= '0;
            r_flush_cnt        <= c_FLUSH_INIT;
            cordic_angle       <= '0;
            cordic_angle_valid <= 1'b0;
        end else begin
            if (w_flush) begin
                r_flush_cnt <= r_flush_cnt - 1'b1;
            end
            cordic_angle_valid <= w_fire;
            if (w_fire) begin
                cordic_angle <= req_angle[int'(w_gnt_idx)*ANGLE_W +: ANGLE_W];
                r_issue_idx  <= w_gnt_idx;
                r_ptr        <= (w_gnt_idx == c_IDX_W'(N_REQ - 1)) ? '0 : w_gnt_idx + 1'b1;
            end
        end
    end

    // Tag pipe mirrors the core: the last stage lines up with cordic_out_valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tag_v <= '0;
            for (int k = 0; k < LATENCY; k++) begin
                r_tag_idx[k] <= '0;
            end
        end else begin
            r_tag_v      <= {r_tag_v[LATENCY-2:0], cordic_angle_valid};
            r_tag_idx[0] <= r_issue_idx;
            for (int k = 1; k < LATENCY; k++) begin
                r_tag_idx[k] <= r_tag_idx[k-1];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_valid <= 1'b0;
            res_idx   <= '0;
            res_sin   <= '0;
            res_cos   <= '0;
            err       <= 1'b0;
        end else begin
            res_valid <= 1'b0;
            if (!w_flush) begin
                if (w_tag_v && cordic_out_valid) begin
                    res_valid <= 1'b1;
                    res_idx   <= r_tag_idx[LATENCY-1];
                    res_sin   <= cordic_sin;
                    res_cos   <= cordic_cos;
                end else if (w_tag_v != cordic_out_valid) begin
                    err <= 1'b1;
                end
            end
        end
    end

`ifdef CORDIC_SCHED_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_issued <= '0;
            stat_stall  <= '0;
        end else begin
            if (w_fire) begin
                stat_issued <= stat_issued + 32'd1;
            end
            if ((|req_valid) && !w_fire) begin
                stat_stall <= stat_stall + 32'd1;
            end
        end
    end
`else
    // Statistics counters not built.
`endif

endmodule
`default_nettype wire

// File: tb/tb_cordic_osc_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cordic_osc_scheduler
//  Description : Directed self-checking bench with a behavioural pipelined
//                CORDIC stand-in (sin = sign-extended angle, cos = sin ^ 5A5A).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cordic_osc_scheduler;

    localparam int N_REQ   = 4;
    localparam int LATENCY = 20;
    localparam int ANGLE_W = 14;
    localparam int OUT_W   = 16;

    logic                     clk = 1'b0;
    logic                     rst;
    logic                     en;
    logic [N_REQ-1:0]         req_valid;
    logic [N_REQ*ANGLE_W-1:0] req_angle;
    logic [N_REQ-1:0]         req_ready;
    logic [ANGLE_W-1:0]       cordic_angle;
    logic                     cordic_angle_valid;
    logic [OUT_W-1:0]         cordic_sin;
    logic [OUT_W-1:0]         cordic_cos;
    logic                     cordic_out_valid;
    logic                     res_valid;
    logic [1:0]               res_idx;
    logic [OUT_W-1:0]         res_sin;
    logic [OUT_W-1:0]         res_cos;
    logic                     err;
`ifdef CORDIC_SCHED_STATS_EN
    logic [31:0]              stat_issued;
    logic [31:0]              stat_stall;
`endif

    cordic_osc_scheduler #(
        .N_REQ(N_REQ), .LATENCY(LATENCY), .ANGLE_W(ANGLE_W), .OUT_W(OUT_W)
    ) dut (
        .clk(clk), .rst(rst), .en(en),
        .req_valid(req_valid), .req_angle(req_angle), .req_ready(req_ready),
        .cordic_angle(cordic_angle), .cordic_angle_valid(cordic_angle_valid),
        .cordic_sin(cordic_sin), .cordic_cos(cordic_cos),
        .cordic_out_valid(cordic_out_valid),
        .res_valid(res_valid), .res_idx(res_idx),
        .res_sin(res_sin), .res_cos(res_cos), .err(err)
`ifdef CORDIC_SCHED_STATS_EN
       ,.stat_issued(stat_issued), .stat_stall(stat_stall)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Unreset pipelined core model
    logic [LATENCY-1:0] m_v = '0;
    logic [ANGLE_W-1:0] m_a [LATENCY];
    logic               force_v = 1'b0;

    function automatic logic [OUT_W-1:0] m_sin(input logic [ANGLE_W-1:0] a);
        return {{(OUT_W-ANGLE_W){a[ANGLE_W-1]}}, a};
    endfunction

    always @(posedge clk) begin
        m_v    <= {m_v[LATENCY-2:0], cordic_angle_valid};
        m_a[0] <= cordic_angle;
        for (int k = 1; k < LATENCY; k++) m_a[k] <= m_a[k-1];
    end

    assign cordic_out_valid = m_v[LATENCY-1] | force_v;
    assign cordic_sin       = m_sin(m_a[LATENCY-1]);
    assign cordic_cos       = m_sin(m_a[LATENCY-1]) ^ 16'h5A5A;

    typedef struct {
        int               c;
        int               idx;
        logic [OUT_W-1:0] s;
        logic [OUT_W-1:0] co;
    } res_t;
    res_t rq[$];

    always @(negedge clk) begin
        if (res_valid) rq.push_back('{c: cyc, idx: int'(res_idx), s: res_sin, co: res_cos});
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [ANGLE_W-1:0] ang(input int i);
        logic [N_REQ*ANGLE_W-1:0] v;
        v = req_angle;
        return v[i*ANGLE_W +: ANGLE_W];
    endfunction

    int t0;
    int nblk;
    int ngr;
    int ei;

    initial begin
        rst       = 1'b1;
        en        = 1'b0;
        req_valid = '0;
        req_angle = {14'h3F00, 14'h0800, 14'h1ABC, 14'h0123};
        repeat (3) @(negedge clk);
        #1;
        check("rst_ready", 32'(req_ready), 32'h0);
        check("rst_cav", 32'(cordic_angle_valid), 32'h0);
        check("rst_angle", 32'(cordic_angle), 32'h0);
        check("rst_res_valid", 32'(res_valid), 32'h0);
        check("rst_res_sin", 32'(res_sin), 32'h0);
        check("rst_err", 32'(err), 32'h0);

        // Flush window then round-robin with all requesters valid
        @(negedge clk);
        rst = 1'b0; en = 1'b1; req_valid = 4'hF;
        nblk = 0;
        for (int i = 0; i < LATENCY + 1; i++) begin
            #1;
            if (req_ready != '0) nblk++;
            @(negedge clk);
        end
        check("flush_block", 32'(nblk), 32'h0);
        t0 = cyc;
        for (int g = 0; g < 8; g++) begin
            #1;
            check("rr_all", 32'(req_ready), 32'(1 << (g % 4)));
            @(negedge clk);
        end
        req_valid = '0;
        repeat (30) @(negedge clk);
        check("rr_all_count", 32'(rq.size()), 32'd8);
        if (rq.size() > 0) check("rr_all_lat", 32'(rq[0].c), 32'(t0 + 22));
        rq.delete();

        // Single request from requester 2
        req_valid = 4'b0100;
        #1;
        check("single_ready", 32'(req_ready), 32'h4);
        t0 = cyc;
        @(negedge clk);
        req_valid = '0;
        #1;
        check("single_cav", 32'(cordic_angle_valid), 32'h1);
        check("single_angle", 32'(cordic_angle), 32'h0800);
        repeat (30) @(negedge clk);
        check("single_count", 32'(rq.size()), 32'd1);
        if (rq.size() > 0) begin
            check("single_lat", 32'(rq[0].c), 32'(t0 + 22));
            check("single_idx", 32'(rq[0].idx), 32'd2);
            check("single_sin", 32'(rq[0].s), 32'h0800);
            check("single_cos", 32'(rq[0].co), 32'h525A);
        end
        rq.delete();

        // Two requesters; pointer sits at 3 after the grant to 2
        req_valid = 4'b1010;
        for (int g = 0; g < 4; g++) begin
            #1;
            check("alt_ready", 32'(req_ready), (g % 2 == 0) ? 32'h8 : 32'h2);
            @(negedge clk);
        end
        req_valid = '0;
        repeat (30) @(negedge clk);
        check("alt_count", 32'(rq.size()), 32'd4);
        for (int g = 0; g < 4 && g < rq.size(); g++) begin
            ei = (g % 2 == 0) ? 3 : 1;
            check("alt_idx", 32'(rq[g].idx), 32'(ei));
            check("alt_sin", 32'(rq[g].s), 32'(m_sin(ang(ei))));
            check("alt_back2back", 32'(rq[g].c), 32'(rq[0].c + g));
        end
        check("alt_neg_sin", 32'(m_sin(ang(3))), 32'hFF00);
        rq.delete();

        // en drop with five tags in flight; pointer starts at 2
        req_valid = 4'hF;
        for (int g = 0; g < 5; g++) begin
            #1;
            check("en_grant", 32'(req_ready), 32'(1 << ((2 + g) % 4)));
            @(negedge clk);
        end
        en = 1'b0;
        #1;
        check("en_off_ready", 32'(req_ready), 32'h0);
        repeat (30) @(negedge clk);
        check("en_off_count", 32'(rq.size()), 32'd5);
        for (int g = 0; g < 5 && g < rq.size(); g++) begin
            check("en_off_idx", 32'(rq[g].idx), 32'((2 + g) % 4));
        end
        req_valid = '0;
        rq.delete();

        // Spurious core valid with an empty tag pipe
        check("pre_err", 32'(err), 32'h0);
        force_v = 1'b1;
        @(negedge clk);
        force_v = 1'b0;
        #1;
        check("mis_err", 32'(err), 32'h1);
        check("mis_res_valid", 32'(res_valid), 32'h0);
        repeat (5) @(negedge clk);
        check("mis_err_sticky", 32'(err), 32'h1);
        check("mis_no_result", 32'(rq.size()), 32'd0);

        // Reset pulse with 20 requests in flight
        en = 1'b1; req_valid = 4'hF;
        repeat (20) @(negedge clk);
        rst = 1'b1;
        #1;
        check("mid_rst_err", 32'(err), 32'h0);
        check("mid_rst_ready", 32'(req_ready), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        rq.delete();
        nblk = 0;
        for (int i = 0; i < LATENCY + 1; i++) begin
            #1;
            if (req_ready != '0 || err || res_valid) nblk++;
            @(negedge clk);
        end
        check("mid_flush_quiet", 32'(nblk), 32'h0);
        check("mid_flush_nores", 32'(rq.size()), 32'd0);
        #1;
        check("mid_first_grant", 32'(req_ready), 32'h1);
        ngr = 0;
        for (int i = 0; i < 8; i++) begin
            #1;
            if ((req_ready & req_valid) != '0) ngr++;
            @(negedge clk);
        end
        req_valid = '0;
        repeat (30) @(negedge clk);
        check("mid_grants", 32'(ngr), 32'd8);
        check("mid_results", 32'(rq.size()), 32'd8);
        check("mid_err", 32'(err), 32'h0);
`ifdef CORDIC_SCHED_STATS_EN
        check("stat_issued", stat_issued, 32'd8);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
